// File: rtl/elevator_call_scheduler.sv
// elevator_call_scheduler
// SCAN (collective) call scheduler and motion sequencer for an elevator car.
// Hall/cab calls are latched per floor and served in the current direction
// while any call remains ahead; the car reverses only from IDLE. One shared
// down-counter times both floor-to-floor travel and door dwell.
//
// Handshake: there is no valid/ready pair here. call_i is a level-sampled
// request vector, observed on every rising edge of clk_i. A call bit is
// captured into pending_o on that edge unless the same edge services the
// floor. pending_o is the sole source for all scheduling decisions.

module elevator_call_scheduler #(
    parameter int NB_FLOORS     = 4,
    parameter int TRAVEL_CYCLES = 8,
    parameter int DOOR_CYCLES   = 4,
    localparam int FW           = (NB_FLOORS > 2) ? $clog2(NB_FLOORS) : 1
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic [NB_FLOORS-1:0] call_i,
    output logic [NB_FLOORS-1:0] pending_o,
    output logic [FW-1:0]        floor_o,
    output logic                 moving_o,
    output logic                 dir_up_o,
    output logic                 open_o
);

    // The timer only ever holds reload values minus one, so size it for the
    // longer of the two intervals.
    localparam int MAX_CYC = (TRAVEL_CYCLES > DOOR_CYCLES) ? TRAVEL_CYCLES : DOOR_CYCLES;
    localparam int TW      = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

    localparam logic [TW-1:0] TRAVEL_LOAD = TW'(TRAVEL_CYCLES - 1);
    localparam logic [TW-1:0] DOOR_LOAD   = TW'(DOOR_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MOVE = 2'd1,
        ST_OPEN = 2'd2
    } state_t;

    state_t                 state_q, state_d;
    logic [FW-1:0]          floor_q, floor_d;
    logic                   dir_up_q, dir_up_d;
    logic [NB_FLOORS-1:0]   pending_q, pending_d;
    logic [TW-1:0]          timer_q, timer_d;

    logic [NB_FLOORS-1:0]   here_mask;
    logic [NB_FLOORS-1:0]   above_mask;
    logic [NB_FLOORS-1:0]   below_mask;
    logic [NB_FLOORS-1:0]   next_mask;
    logic [FW-1:0]          next_floor;
    logic                   call_ahead;
    logic                   call_behind;
    logic [NB_FLOORS-1:0]   clear_mask;
    logic [NB_FLOORS-1:0]   call_mask;

    // Floor-relative masks: current floor, floors above/below it, and the
    // floor the car reaches at the end of the current travel step.
    always_comb begin
        here_mask  = '0;
        above_mask = '0;
        below_mask = '0;
        next_mask  = '0;
        next_floor = dir_up_q ? (floor_q + FW'(1)) : (floor_q - FW'(1));
        for (int i = 0; i < NB_FLOORS; i++) begin
            if (FW'(i) == floor_q)    here_mask[i]  = 1'b1;
            if (FW'(i) >  floor_q)    above_mask[i] = 1'b1;
            if (FW'(i) <  floor_q)    below_mask[i] = 1'b1;
            if (FW'(i) == next_floor) next_mask[i]  = 1'b1;
        end
        call_ahead  = dir_up_q ? |(pending_q & above_mask) : |(pending_q & below_mask);
        call_behind = dir_up_q ? |(pending_q & below_mask) : |(pending_q & above_mask);
    end

    // Next-state, timer and call-capture logic for the IDLE/MOVE/OPEN sequencer.
    always_comb begin
        state_d    = state_q;
        floor_d    = floor_q;
        dir_up_d   = dir_up_q;
        timer_d    = timer_q;
        clear_mask = '0;
        call_mask  = call_i;

        case (state_q)
            ST_IDLE: begin
                if (|(pending_q & here_mask)) begin
                    state_d    = ST_OPEN;
                    clear_mask = here_mask;
                    timer_d    = DOOR_LOAD;
                end else if (call_ahead) begin
                    state_d = ST_MOVE;
                    timer_d = TRAVEL_LOAD;
                end else if (call_behind) begin
                    // The only place the car reverses.
                    dir_up_d = ~dir_up_q;
                    state_d  = ST_MOVE;
                    timer_d  = TRAVEL_LOAD;
                end
            end

            ST_MOVE: begin
                if (timer_q != '0) begin
                    timer_d = timer_q - TW'(1);
                end else begin
                    floor_d = next_floor;
                    if (|(pending_q & next_mask)) begin
                        state_d    = ST_OPEN;
                        clear_mask = next_mask;
                        timer_d    = DOOR_LOAD;
                    end else begin
                        // Pending bits only clear on service, so a call is
                        // still ahead and the car keeps going.
                        timer_d = TRAVEL_LOAD;
                    end
                end
            end

            ST_OPEN: begin
                // A call at the open floor holds the door instead of latching.
                call_mask = call_i & ~here_mask;
                if (|(call_i & here_mask)) begin
                    timer_d = DOOR_LOAD;
                end else if (timer_q != '0) begin
                    timer_d = timer_q - TW'(1);
                end else begin
                    state_d = ST_IDLE;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Clearing wins over a same-edge call for the served floor.
        pending_d = (pending_q | call_mask) & ~clear_mask;
    end

    // State, position, direction, call and timer registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= ST_IDLE;
            floor_q   <= '0;
            dir_up_q  <= 1'b1;
            pending_q <= '0;
            timer_q   <= '0;
        end else begin
            state_q   <= state_d;
            floor_q   <= floor_d;
            dir_up_q  <= dir_up_d;
            pending_q <= pending_d;
            timer_q   <= timer_d;
        end
    end

    assign pending_o = pending_q;
    assign floor_o   = floor_q;
    assign dir_up_o  = dir_up_q;
    assign moving_o  = (state_q == ST_MOVE);
    assign open_o    = (state_q == ST_OPEN);

endmodule

// File: tb/tb_elevator_call_scheduler.sv
// Testbench for elevator_call_scheduler: a default-parameter car plus a
// two-floor, single-cycle car for the end-floor boundary.

module tb_elevator_call_scheduler;

    localparam int FW = 2;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst;
    logic [3:0]    call;
    logic [3:0]    pending;
    logic [FW-1:0] floor_v;
    logic          moving, dir_up, open_v;

    logic          rst2;
    logic [1:0]    call2;
    logic [1:0]    pending2;
    logic [0:0]    floor2;
    logic          moving2, dir2, open2;

    elevator_call_scheduler #(
        .NB_FLOORS(4), .TRAVEL_CYCLES(8), .DOOR_CYCLES(4)
    ) dut (
        .clk_i(clk), .rst_i(rst), .call_i(call), .pending_o(pending),
        .floor_o(floor_v), .moving_o(moving), .dir_up_o(dir_up), .open_o(open_v)
    );

    elevator_call_scheduler #(
        .NB_FLOORS(2), .TRAVEL_CYCLES(1), .DOOR_CYCLES(1)
    ) dut2 (
        .clk_i(clk), .rst_i(rst2), .call_i(call2), .pending_o(pending2),
        .floor_o(floor2), .moving_o(moving2), .dir_up_o(dir2), .open_o(open2)
    );

    // ---------------- scoreboard ----------------
    int n_checks = 0;
    int n_fail   = 0;
    logic [FW-1:0] exp_q[$];
    logic [0:0]    exp2_q[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Each door opening is an arrival; its floor must match the expected
    // service order.
    logic open_prev = 1'b0;
    always @(negedge clk) begin
        check("excl", {31'b0, moving & open_v}, 32'd0);
        if (open_v && !open_prev) begin
            check("arrive_expected", {31'b0, exp_q.size() != 0}, 32'd1);
            if (exp_q.size() != 0) check("arrive_floor", {30'b0, floor_v}, {30'b0, exp_q.pop_front()});
        end
        open_prev <= open_v;
    end

    // Two-floor car: arrival floor order and a single-cycle door per arrival.
    logic open2_prev = 1'b0;
    int   open2_len  = 0;
    always @(negedge clk) begin
        check("excl2", {31'b0, moving2 & open2}, 32'd0);
        if (open2 && !open2_prev) begin
            check("arrive2_expected", {31'b0, exp2_q.size() != 0}, 32'd1);
            if (exp2_q.size() != 0) check("arrive2_floor", {31'b0, floor2}, {31'b0, exp2_q.pop_front()});
        end
        if (!open2 && open2_prev) check("open2_len", open2_len, 32'd1);
        open2_len  <= open2 ? open2_len + 1 : 0;
        open2_prev <= open2;
    end

    // ---------------- driver tasks ----------------
    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_idle(input int budget);
        int n = 0;
        while ((moving || open_v || (pending != 4'b0)) && n < budget) begin
            @(negedge clk);
            n++;
        end
        check("wait_idle", {31'b0, moving | open_v | (|pending)}, 32'd0);
    endtask

    task automatic wait_idle2(input int budget);
        int n = 0;
        while ((moving2 || open2 || (pending2 != 2'b0)) && n < budget) begin
            @(negedge clk);
            n++;
        end
        check("wait_idle2", {31'b0, moving2 | open2 | (|pending2)}, 32'd0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_pending"}, {28'b0, pending}, 32'd0);
        check({tag, "_floor"},   {30'b0, floor_v}, 32'd0);
        check({tag, "_moving"},  {31'b0, moving},  32'd0);
        check({tag, "_open"},    {31'b0, open_v},  32'd0);
        check({tag, "_dir"},     {31'b0, dir_up},  32'd1);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int tgt;
        rst = 1'b1; call = '0;
        rst2 = 1'b1; call2 = '0;
        cyc(2);
        check_reset_outputs("reset");
        rst = 1'b0; rst2 = 1'b0;

        // Single call to floor 2 from floor 0.
        call = 4'b0100; exp_q.push_back(2'd2);
        cyc(1);                                   // edge 1
        check("t2_pending", {28'b0, pending}, 32'h4);
        check("t2_moving_e1", {31'b0, moving}, 32'd0);
        call = 4'b0;
        cyc(1);                                   // edge 2
        check("t2_moving_e2", {31'b0, moving}, 32'd1);
        cyc(7);                                   // edge 9
        check("t2_floor_e9", {30'b0, floor_v}, 32'd0);
        cyc(1);                                   // edge 10
        check("t2_floor_e10", {30'b0, floor_v}, 32'd1);
        check("t2_moving_e10", {31'b0, moving}, 32'd1);
        cyc(8);                                   // edge 18
        check("t2_floor_e18", {30'b0, floor_v}, 32'd2);
        check("t2_open_e18", {31'b0, open_v}, 32'd1);
        check("t2_pending_e18", {28'b0, pending}, 32'd0);
        cyc(3);                                   // edge 21
        check("t2_open_e21", {31'b0, open_v}, 32'd1);
        cyc(1);                                   // edge 22
        check("t2_open_e22", {31'b0, open_v}, 32'd0);
        check("t2_moving_e22", {31'b0, moving}, 32'd0);

        // Call behind from floor 2: reverse, then reset mid-move at floor 1.
        call = 4'b0001;
        cyc(1);
        call = 4'b0;
        cyc(1);
        check("rev_dir", {31'b0, dir_up}, 32'd0);
        check("rev_moving", {31'b0, moving}, 32'd1);
        cyc(8);
        check("rev_floor1", {30'b0, floor_v}, 32'd1);
        cyc(3);
        check("rev_still_moving", {31'b0, moving}, 32'd1);
        rst = 1'b1;
        cyc(1);
        check_reset_outputs("midmove_reset");
        rst = 1'b0;

        // Current-floor call in IDLE, then door held by call_i[0].
        call = 4'b0001; exp_q.push_back(2'd0);
        cyc(1);
        check("t3_pending", {28'b0, pending}, 32'h1);
        check("t3_open_early", {31'b0, open_v}, 32'd0);
        call = 4'b0;
        cyc(1);
        check("t3_open", {31'b0, open_v}, 32'd1);
        check("t3_pending_clr", {28'b0, pending}, 32'd0);
        call = 4'b0001;
        cyc(6);
        check("t3_held_open", {31'b0, open_v}, 32'd1);
        check("t3_not_latched", {28'b0, pending}, 32'd0);
        call = 4'b0;
        cyc(3);
        check("t3_open_after_release", {31'b0, open_v}, 32'd1);
        cyc(1);
        check("t3_closed", {31'b0, open_v}, 32'd0);
        check("t3_no_motion", {31'b0, moving}, 32'd0);

        // Simultaneous calls 0 and 3; re-call of 3 on its arrival edge.
        call = 4'b1001; exp_q.push_back(2'd0); exp_q.push_back(2'd3);
        cyc(1);                                   // edge 1
        call = 4'b0;
        cyc(1);                                   // edge 2
        check("t5_open0", {31'b0, open_v}, 32'd1);
        check("t5_pending", {28'b0, pending}, 32'h8);
        cyc(28);                                  // edge 30
        check("t5_floor2", {30'b0, floor_v}, 32'd2);
        check("t5_moving", {31'b0, moving}, 32'd1);
        call = 4'b1000;
        cyc(1);                                   // edge 31 (arrival)
        call = 4'b0;
        check("t5_floor3", {30'b0, floor_v}, 32'd3);
        check("t5_open3", {31'b0, open_v}, 32'd1);
        check("t5_pending_arr", {28'b0, pending}, 32'd0);
        cyc(4);                                   // edge 35
        check("t5_closed", {31'b0, open_v}, 32'd0);
        check("t5_not_relatched", {28'b0, pending}, 32'd0);

        // SCAN order: moving up past floor 1 toward 3, add calls 0 and 2.
        rst = 1'b1;
        cyc(1);
        rst = 1'b0;
        call = 4'b1000;
        cyc(1);                                   // edge 1
        call = 4'b0;
        cyc(9);                                   // edge 10
        check("t4_floor1", {30'b0, floor_v}, 32'd1);
        check("t4_dir_up", {31'b0, dir_up}, 32'd1);
        call = 4'b0101;
        exp_q.push_back(2'd2); exp_q.push_back(2'd3); exp_q.push_back(2'd0);
        cyc(1);                                   // edge 11
        call = 4'b0;
        check("t4_pending", {28'b0, pending}, 32'hD);
        cyc(7);                                   // edge 18
        check("t4_open2", {31'b0, open_v}, 32'd1);
        check("t4_pending2", {28'b0, pending}, 32'h9);
        cyc(17);                                  // edge 35
        check("t4_idle3_dir", {31'b0, dir_up}, 32'd1);
        check("t4_idle3_floor", {30'b0, floor_v}, 32'd3);
        cyc(1);                                   // edge 36
        check("t4_reversed", {31'b0, dir_up}, 32'd0);
        check("t4_reverse_moving", {31'b0, moving}, 32'd1);
        wait_idle(100);
        check("t4_end_floor", {30'b0, floor_v}, 32'd0);
        check("t4_end_dir", {31'b0, dir_up}, 32'd0);

        // Random single calls from idle.
        for (int i = 0; i < 6; i++) begin
            tgt = $urandom_range(0, 3);
            call = 4'(1 << tgt);
            exp_q.push_back(FW'(tgt));
            cyc(1);
            call = 4'b0;
            wait_idle(120);
            check("rand_floor", {30'b0, floor_v}, tgt);
        end

        // Two-floor boundary car: alternate calls.
        for (int i = 0; i < 6; i++) begin
            tgt = (i % 2 == 0) ? 1 : 0;
            call2 = (tgt == 1) ? 2'b10 : 2'b01;
            exp2_q.push_back(1'(tgt));
            cyc(1);
            call2 = 2'b0;
            wait_idle2(20);
            check("t6_floor", {31'b0, floor2}, tgt);
        end

        cyc(3);
        check("sb_empty", exp_q.size(), 32'd0);
        check("sb2_empty", exp2_q.size(), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
